// File: rtl/ysyx_23060251_axi_pkg.sv
// Shared AXI4-Lite types for the interconnect and its slaves.
// Response codes, slave FSM states and default bus widths.
package ysyx_23060251_axi_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4, loadable seed on reset.
// Used to randomise SRAM response latency.
module lfsr8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      q <= seed;
    else if (en)
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/axi_sram_slv.sv
// AXI4-Lite word SRAM slave with programmable response latency.
// YSYX_23060251_SRAM_RAND_DELAY_EN: per-transaction LFSR latency 1..16.
module axi_sram_slv
  import ysyx_23060251_axi_pkg::*;
#(
  parameter int              ADDR_W    = ADDR_W_DEF,
  parameter int              DATA_W    = DATA_W_DEF,
  parameter int              DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int              LATENCY   = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ar_valid,
  output logic                ar_ready,
  input  logic [ADDR_W-1:0]   ar_addr,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [DATA_W-1:0]   r_data,
  output logic [1:0]          r_resp,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  output logic                b_valid,
  input  logic                b_ready,
  output logic [1:0]          b_resp
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 16) + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic hit(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - BASE_ADDR) >> OFF_W;
    return (a >= BASE_ADDR) && (off < ADDR_W'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = (a - BASE_ADDR) >> OFF_W;
    return off[IDX_W-1:0];
  endfunction

  // Latency minus one, sampled when a transaction enters its wait phase
  logic [CNT_W-1:0] rd_lat_m1;
  logic [CNT_W-1:0] wr_lat_m1;

`ifdef YSYX_23060251_SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  lfsr8 u_lfsr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en    (1'b1),
    .seed  (8'hA5),
    .q     (lfsr)
  );

  assign rd_lat_m1 = CNT_W'(lfsr[3:0]);
  assign wr_lat_m1 = CNT_W'(lfsr[7:4]);
`else
  assign rd_lat_m1 = CNT_W'(LATENCY - 1);
  assign wr_lat_m1 = CNT_W'(LATENCY - 1);
`endif

  // ---------------- read path ----------------
  rd_state_e         rd_state;
  rd_state_e         rd_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [ADDR_W-1:0] r_src;
  logic              ar_hs;
  logic              r_fire;
  logic              r_hit;
  logic [IDX_W-1:0]  r_idx;

  assign ar_hs  = ar_valid && ar_ready;
  assign r_src  = (rd_state == R_IDLE) ? ar_addr : ar_addr_q;
  assign r_hit  = hit(r_src);
  assign r_idx  = idx(r_src);
  assign r_fire = (rd_next == R_RESP) && (rd_state != R_RESP);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      rd_state <= R_IDLE;
    else
      rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      R_IDLE:
        if (ar_hs)
          rd_next = (rd_lat_m1 == '0) ? R_RESP : R_WAIT;
      R_WAIT:
        if (r_cnt == CNT_W'(1))
          rd_next = R_RESP;
      R_RESP:
        if (r_ready)
          rd_next = R_IDLE;
      default:
        rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready = (rd_state == R_IDLE);
    r_valid  = (rd_state == R_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      ar_addr_q <= '0;
      r_data    <= '0;
      r_resp    <= OKAY;
    end else begin
      if (ar_hs)
        ar_addr_q <= ar_addr;
      if (rd_state == R_IDLE)
        r_cnt <= rd_lat_m1;
      else if (rd_state == R_WAIT)
        r_cnt <= r_cnt - CNT_W'(1);
      if (r_fire) begin
        r_data <= r_hit ? mem[r_idx] : '0;
        r_resp <= r_hit ? OKAY : DECERR;
      end
    end
  end

  // ---------------- write path ----------------
  wr_state_e         wr_state;
  wr_state_e         wr_next;
  logic [CNT_W-1:0]  w_cnt;
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [BYTES-1:0]  w_strb_q;
  logic              aw_hs;
  logic              w_hs;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [BYTES-1:0]  ws;
  logic              w_fire;
  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;

  assign aw_hs  = aw_valid && aw_ready;
  assign w_hs   = w_valid && w_ready;
  // A beat arriving this cycle is used directly so LATENCY=1 commits on time
  assign wa     = aw_held ? aw_addr_q : aw_addr;
  assign wd     = w_held ? w_data_q : w_data;
  assign ws     = w_held ? w_strb_q : w_strb;
  assign w_hit  = hit(wa);
  assign w_idx  = idx(wa);
  assign w_fire = (wr_next == W_RESP) && (wr_state != W_RESP);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      wr_state <= W_IDLE;
    else
      wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE:
        if ((aw_held || aw_hs) && (w_held || w_hs))
          wr_next = (wr_lat_m1 == '0) ? W_RESP : W_WAIT;
      W_WAIT:
        if (w_cnt == CNT_W'(1))
          wr_next = W_RESP;
      W_RESP:
        if (b_ready)
          wr_next = W_IDLE;
      default:
        wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready = (wr_state == W_IDLE) && !aw_held;
    w_ready  = (wr_state == W_IDLE) && !w_held;
    b_valid  = (wr_state == W_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      w_cnt     <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp    <= OKAY;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= aw_addr;
      end
      if (w_hs) begin
        w_held   <= 1'b1;
        w_data_q <= w_data;
        w_strb_q <= w_strb;
      end
      if (b_valid && b_ready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      if (wr_state == W_IDLE)
        w_cnt <= wr_lat_m1;
      else if (wr_state == W_WAIT)
        w_cnt <= w_cnt - CNT_W'(1);
      if (w_fire)
        b_resp <= w_hit ? OKAY : DECERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && w_fire && w_hit)
      for (int i = 0; i < BYTES; i++)
        if (ws[i])
          mem[w_idx][8*i +: 8] <= wd[8*i +: 8];
  end

  // Masters must hold valid until the matching ready
  a_ar_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    ar_valid && !ar_ready |=> ar_valid);
  a_aw_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    aw_valid && !aw_ready |=> aw_valid);
  a_w_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    w_valid && !w_ready |=> w_valid);

endmodule
